// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx
//
// Purpose:
//   Sends the crane command byte from the button encoder over the radio/UART
//   link as 8N1 frames (one start bit, eight data bits LSB first, one stop bit).
//   A frame goes out whenever the command byte differs from the last byte sent.
//   A keep-alive frame repeats the current byte after a long idle stretch, so
//   the receiver can detect when the link is lost.
//
// Parameters:
//   CLKS_PER_BIT     - clock cycles per UART bit (>= 2)
//   KEEPALIVE_CYCLES - idle cycles before the current byte is resent (>= 2)
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   cmd_byte - {speed[1:0], cw, ccw, arm_up, arm_down, line_up, line_down}
//   tx       - UART serial line, idles high (registered)
//   busy     - high while start, data or stop bit is on the line (registered)
//   sent     - one-cycle pulse on the final cycle of the stop bit
module cmd_uart_tx #(
  parameter int CLKS_PER_BIT     = 868,
  parameter int KEEPALIVE_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_byte,
  output logic       tx,
  output logic       busy,
  output logic       sent
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int KA_W   = $clog2(KEEPALIVE_CYCLES);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [KA_W-1:0]   KA_LAST   = KA_W'(KEEPALIVE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              r_state;
  logic [7:0]          r_shift;
  logic [7:0]          r_lastSent;
  logic [2:0]          r_bitIdx;
  logic [BAUD_W-1:0]   r_baudCnt;
  logic [KA_W-1:0]     r_kaCnt;
  logic                r_tx;
  logic                r_busy;

  state_t              w_stateNext;
  logic [7:0]          w_shiftNext;
  logic [7:0]          w_lastSentNext;
  logic [2:0]          w_bitIdxNext;
  logic [BAUD_W-1:0]   w_baudCntNext;
  logic [KA_W-1:0]     w_kaCntNext;
  logic                w_txNext;
  logic                w_busyNext;
  logic                w_bitDone;
  logic                w_trigger;

  // State register and all datapath registers. Reset aborts any frame in
  // flight: the line goes high and busy drops on the very next cycle, and
  // last_sent returns to zero so a nonzero command is resent right away.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= 8'h00;
      r_lastSent <= 8'h00;
      r_bitIdx   <= 3'd0;
      r_baudCnt  <= '0;
      r_kaCnt    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shift    <= w_shiftNext;
      r_lastSent <= w_lastSentNext;
      r_bitIdx   <= w_bitIdxNext;
      r_baudCnt  <= w_baudCntNext;
      r_kaCnt    <= w_kaCntNext;
      r_tx       <= w_txNext;
      r_busy     <= w_busyNext;
    end
  end

  // Next-state logic. tx and busy are computed one cycle ahead so they come
  // straight out of flops: the value chosen here for the next state's first
  // bit is what appears on the line the cycle after the decision. A change and
  // a keep-alive expiry on the same cycle fold into a single trigger, so only
  // one frame with the current byte is sent.
  always_comb begin
    w_stateNext    = r_state;
    w_shiftNext    = r_shift;
    w_lastSentNext = r_lastSent;
    w_bitIdxNext   = r_bitIdx;
    w_baudCntNext  = r_baudCnt;
    w_kaCntNext    = r_kaCnt;
    w_txNext       = r_tx;
    w_busyNext     = r_busy;
    w_bitDone      = (r_baudCnt == BAUD_LAST);
    w_trigger      = (cmd_byte != r_lastSent) || (r_kaCnt == KA_LAST);

    case (r_state)
      IDLE: begin
        w_txNext     = 1'b1;
        w_busyNext   = 1'b0;
        w_bitIdxNext = 3'd0;
        if (r_kaCnt != KA_LAST) begin
          w_kaCntNext = r_kaCnt + 1'b1;
        end
        if (w_trigger) begin
          w_shiftNext    = cmd_byte;
          w_lastSentNext = cmd_byte;
          w_kaCntNext    = '0;
          w_baudCntNext  = '0;
          w_stateNext    = START;
          w_txNext       = 1'b0;
          w_busyNext     = 1'b1;
        end
      end

      START: begin
        w_kaCntNext = '0;
        if (w_bitDone) begin
          w_baudCntNext = '0;
          w_bitIdxNext  = 3'd0;
          w_stateNext   = DATA;
          w_txNext      = r_shift[0];
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end

      DATA: begin
        w_kaCntNext = '0;
        if (w_bitDone) begin
          w_baudCntNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
            w_txNext    = 1'b1;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
            w_txNext     = r_shift[w_bitIdxNext];
          end
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end

      STOP: begin
        w_kaCntNext = '0;
        if (w_bitDone) begin
          w_baudCntNext = '0;
          w_stateNext   = IDLE;
          w_txNext      = 1'b1;
          w_busyNext    = 1'b0;
        end else begin
          w_baudCntNext = r_baudCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
        w_txNext    = 1'b1;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  // The sent pulse marks the last cycle of the stop bit, which is exactly
  // when the STOP state sees its bit timer expire.
  assign sent = (r_state == STOP) && w_bitDone;
  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// tb_cmd_uart_tx
//
// Self-checking bench for cmd_uart_tx with CLKS_PER_BIT = 4 and
// KEEPALIVE_CYCLES = 100. A frame-level model predicts tx/busy/sent every
// cycle; a line monitor decodes the frames the DUT actually sends, and
// directed checks pin their start times and contents to hand-computed values.
module tb_cmd_uart_tx;

  localparam int CPB   = 4;
  localparam int KA    = 100;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_byte;
  logic       tx;
  logic       busy;
  logic       sent;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  cmd_uart_tx #(
    .CLKS_PER_BIT    (CPB),
    .KEEPALIVE_CYCLES(KA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_byte(cmd_byte),
    .tx      (tx),
    .busy    (busy),
    .sent    (sent)
  );

  always #5 clk = ~clk;

  // Cycle index: the interval after the n-th rising edge is cycle n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] c);
    rst      = r;
    cmd_byte = c;
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Frame-level model: a frame is either in progress (position 1..FRAME
  // within it) or the line is idle and counting idle cycles.
  bit         mValid  = 1'b0;
  bit         mActive = 1'b0;
  int         mPos    = 0;
  int         mIdle   = 0;
  logic [7:0] mByte   = 8'h00;
  logic [7:0] mLast   = 8'h00;

  function automatic logic expTx(input int pos, input logic [7:0] b);
    if (pos <= CPB) return 1'b0;
    if (pos <= 9 * CPB) return b[(pos - CPB - 1) / CPB];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mValid  <= 1'b1;
      mActive <= 1'b0;
      mLast   <= 8'h00;
      mIdle   <= 0;
      mPos    <= 0;
    end else if (mActive) begin
      if (mPos == FRAME) begin
        mActive <= 1'b0;
        mIdle   <= 0;
      end else begin
        mPos <= mPos + 1;
      end
    end else if (cmd_byte != mLast || mIdle >= KA - 1) begin
      mActive <= 1'b1;
      mPos    <= 1;
      mByte   <= cmd_byte;
      mLast   <= cmd_byte;
    end else begin
      mIdle <= mIdle + 1;
    end
  end

  // Line monitor state: frame starts (busy rising), decoded bytes of frames
  // that ran to the stop bit, sent pulses and last busy duration.
  int         busyStarts[$];
  logic [7:0] frameBytes[$];
  bit         prevBusy    = 1'b0;
  int         dStart      = 0;
  logic [7:0] dByte       = 8'h00;
  int         sentCount   = 0;
  int         lastSentCyc = 0;
  int         lastBusyLen = 0;

  function automatic int posOf(input int c, input int s);
    return c - s + 1;
  endfunction

  function automatic logic [2:0] bitOf(input int pos);
    return 3'((pos - 6) / CPB);
  endfunction

  // Per-cycle comparison against the model plus the line monitor, both on
  // the falling edge where outputs are stable.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("tx", 32'(tx), 32'(mActive ? expTx(mPos, mByte) : 1'b1));
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("sent", 32'(sent), 32'(mActive && mPos == FRAME));

      if (busy && !prevBusy) begin
        dStart <= cyc;
        busyStarts.push_back(cyc);
      end else if (busy) begin
        if (posOf(cyc, dStart) >= 6 && posOf(cyc, dStart) <= 34 &&
            (posOf(cyc, dStart) - 6) % CPB == 0)
          dByte[bitOf(posOf(cyc, dStart))] <= tx;
        if (posOf(cyc, dStart) == 38)
          frameBytes.push_back(dByte);
      end
      if (!busy && prevBusy) lastBusyLen <= cyc - dStart;
      if (sent) begin
        sentCount   <= sentCount + 1;
        lastSentCyc <= cyc;
      end
      prevBusy <= busy;
    end
  end

  task automatic waitSent(input int n, input int budget, input string name);
    int k = 0;
    while (sentCount < n && k < budget) begin
      tick;
      k++;
    end
    checkOutput(name, 32'(sentCount >= n), 32'd1);
  endtask

  task automatic waitUntilCyc(input int target);
    while (cyc < target) tick;
  endtask

  int relCyc;
  int changeCyc;
  int s;
  int L;
  int F;

  initial begin
    applyStimulus(1'b1, 8'h00);
    repeat (3) @(posedge clk);
    tick;
    applyStimulus(1'b0, 8'h00);
    relCyc = cyc;

    // Power-up with 8'h00: only the keep-alive frame, on the 100th idle cycle.
    waitSent(1, 200, "wait_f0");
    checkOutput("f0_start", 32'(busyStarts[0] - relCyc), 32'd100);
    checkOutput("f0_byte", 32'(frameBytes[0]), 32'h00);
    checkOutput("f0_sent_ofs", 32'(lastSentCyc - busyStarts[0]), 32'd39);
    tick;
    checkOutput("f0_busy_len", 32'(lastBusyLen), 32'd40);

    // Single change to 8'hA5.
    applyStimulus(1'b0, 8'hA5);
    changeCyc = cyc;
    waitSent(2, 100, "wait_a5");
    checkOutput("a5_latency", 32'(busyStarts[1] - changeCyc), 32'd1);
    checkOutput("a5_byte", 32'(frameBytes[1]), 32'hA5);
    checkOutput("a5_sent_ofs", 32'(lastSentCyc - busyStarts[1]), 32'd39);
    tick;
    checkOutput("a5_busy_len", 32'(lastBusyLen), 32'd40);

    // Mid-frame changes: 81 goes out, 42 is skipped, 24 follows 41 later.
    tick;
    applyStimulus(1'b0, 8'h81);
    s = cyc + 1;
    waitUntilCyc(s + 9);
    applyStimulus(1'b0, 8'h42);
    waitUntilCyc(s + 19);
    applyStimulus(1'b0, 8'h24);
    waitSent(4, 150, "wait_mid");
    checkOutput("mid_byte0", 32'(frameBytes[2]), 32'h81);
    checkOutput("mid_byte1", 32'(frameBytes[3]), 32'h24);
    checkOutput("mid_gap", 32'(busyStarts[3] - busyStarts[2]), 32'd41);
    checkOutput("mid_count", 32'(busyStarts.size()), 32'd4);

    // Keep-alive: 8'h3C resent every 140 cycles.
    tick;
    applyStimulus(1'b0, 8'h3C);
    waitSent(7, 600, "wait_ka");
    checkOutput("ka_byte0", 32'(frameBytes[4]), 32'h3C);
    checkOutput("ka_byte1", 32'(frameBytes[5]), 32'h3C);
    checkOutput("ka_byte2", 32'(frameBytes[6]), 32'h3C);
    checkOutput("ka_period0", 32'(busyStarts[5] - busyStarts[4]), 32'd140);
    checkOutput("ka_period1", 32'(busyStarts[6] - busyStarts[5]), 32'd140);
    checkOutput("ka_count", 32'(busyStarts.size()), 32'd7);

    // Change to 8'h11 on the cycle the keep-alive count reaches 99.
    L = busyStarts[6];
    waitUntilCyc(L + 139);
    applyStimulus(1'b0, 8'h11);
    waitSent(8, 100, "wait_sim");
    checkOutput("sim_start", 32'(busyStarts[7] - L), 32'd140);
    checkOutput("sim_byte", 32'(frameBytes[7]), 32'h11);
    waitUntilCyc(L + 240);
    checkOutput("sim_count", 32'(busyStarts.size()), 32'd8);

    // Reset during data bit 3 of a 8'h5A frame, then a fresh full frame.
    tick;
    applyStimulus(1'b0, 8'h5A);
    F = cyc + 1;
    waitUntilCyc(F + 17);
    applyStimulus(1'b1, 8'h5A);
    tick;
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 8'h5A);
    waitSent(9, 100, "wait_rst");
    checkOutput("rst_restart", 32'(busyStarts[9] - F), 32'd19);
    checkOutput("rst_byte", 32'(frameBytes[8]), 32'h5A);
    checkOutput("rst_count", 32'(busyStarts.size()), 32'd10);
    repeat (5) tick;
    checkOutput("rst_sent_count", 32'(sentCount), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    nChecks++;
    nFails++;
    $display("[TB] FAIL watchdog: actual timeout required completion (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/cmd_uart_tx.md
# cmd_uart_tx

Serialises the 8-bit crane command byte from the button-encoding stage onto the radio/UART link as 8N1 frames. A frame is sent whenever the command byte differs from the last byte sent. A keep-alive frame is also sent periodically, so the receiver can detect link loss. The block sits directly downstream of the command encoder, and its `tx` drives the UART pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `KEEPALIVE_CYCLES`, default 10_000_000: idle cycles after which the current byte is resent (100 ms at 100 MHz). Must be ≥ 2.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: one clock; reset is synchronous and active-high.
- `cmd_byte` input, 8 bits: command byte {speed[1:0], cw, ccw, arm_up, arm_down, line_up, line_down}. Sampled only in IDLE.
- `tx` output, 1 bit: UART serial line. Idle level is high.
- `busy` output, 1 bit: high while a frame (start, data or stop bit) is on the line.
- `sent` output, 1 bit: one-cycle pulse on the final cycle of the stop bit.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Registers:**
  - `shift[7:0]`
  - `last_sent[7:0]`
  - `bit_idx[2:0]`
  - `baud_cnt`: width is clog2(CLKS_PER_BIT).
  - `ka_cnt`: width is clog2(KEEPALIVE_CYCLES).
- **Reset (synchronous):**
  - state = IDLE, `tx` = 1, `busy` = 0, `sent` = 0.
  - `last_sent` = 8'h00, `ka_cnt` = 0, `baud_cnt` = 0, `bit_idx` = 0.
  - A reset asserted mid-frame aborts the frame. `tx` returns high the cycle after reset is sampled, and no `sent` pulse is issued.
- **IDLE:**
  - `tx` = 1.
  - `ka_cnt` increments each cycle and saturates at KEEPALIVE_CYCLES-1.
  - Trigger condition: (`cmd_byte` != `last_sent`) OR (`ka_cnt` == KEEPALIVE_CYCLES-1).
  - On trigger: `shift` ← `cmd_byte`, `last_sent` ← `cmd_byte`, `ka_cnt` ← 0, `baud_cnt` ← 0, go to START.
  - A change and a keep-alive expiry in the same cycle produce one frame only, carrying the current `cmd_byte`.
- **START:** `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with `bit_idx` = 0.
- **DATA:**
  - `tx` = `shift[bit_idx]`, LSB first.
  - Each bit lasts CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- **STOP:**
  - `tx` = 1 for CLKS_PER_BIT cycles.
  - `sent` = 1 on the last cycle, then go to IDLE.
- **Counting:** `ka_cnt` is held at 0 outside IDLE, so keep-alive timing restarts from the end of each frame.
- **Mid-frame changes:** changes to `cmd_byte` during a frame do not alter that frame. They are compared against `last_sent` when the block returns to IDLE. Intermediate values that come and go within one frame are never sent.
- **Power-up:** `cmd_byte` = 8'h00 at power-up produces no frame until the first keep-alive expiry.

## Timing
- **Latency:** trigger evaluated in IDLE at cycle N → `tx` falls and `busy` rises at N+1. `busy` and `tx` are registered outputs.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles with `busy` = 1.
  - Start bit: cycles N+1 … N+CLKS_PER_BIT.
  - Data bit k: cycles N+1+(k+1)×CLKS_PER_BIT … N+(k+2)×CLKS_PER_BIT.
- **End of frame:** `sent` is high at cycle N+10×CLKS_PER_BIT. `busy` = 0 at the following cycle.
- **Inter-frame gap:** minimum 1 IDLE cycle at `tx` = 1. Back-to-back frames have start edges 10×CLKS_PER_BIT+1 cycles apart.
- **Keep-alive period:** with a steady `cmd_byte`, consecutive frame starts are KEEPALIVE_CYCLES + 10×CLKS_PER_BIT cycles apart.

## Test plan
Bench parameters: CLKS_PER_BIT = 4, KEEPALIVE_CYCLES = 100.
- **Reset state:** hold `rst` 3 cycles with `cmd_byte` = 8'h00, then release → `tx` = 1, `busy` = 0 and `sent` = 0 throughout. First frame (8'h00) starts on the 100th IDLE cycle after release.
- **Single change:** `cmd_byte` 8'h00→8'hA5 in IDLE → next cycle `tx` = 0 for 4 cycles. Data bits 1,0,1,0,0,1,0,1, 4 cycles each. Stop bit high 4 cycles. `sent` pulses once at cycle 40 after the start. `busy` is high for 40 cycles.
- **Mid-frame changes:** `cmd_byte` = 8'h81, then 8'h42 at frame cycle 10, then 8'h24 at frame cycle 20 → frame carries 8'h81. Exactly one further frame follows, carrying 8'h24, starting 41 cycles after the first start.
- **Keep-alive:** `cmd_byte` held at 8'h3C after its frame → resend of 8'h3C every 140 cycles (start to start). No other frames.
- **Simultaneous events:** `cmd_byte` changes to 8'h11 on the same cycle `ka_cnt` reaches 99 → exactly one frame, carrying 8'h11.
- **Reset mid-frame:** assert `rst` during data bit 3 → `tx` = 1 and `busy` = 0 the next cycle, and no `sent` pulse. After release with `cmd_byte` = 8'h5A ≠ 8'h00, a fresh full frame of 8'h5A starts 1 cycle after the first IDLE cycle.
